// File: rtl/pll_lock_sequencer_if.sv
// Status/control bundle between the PLL lock sequencer and the PLL, the core reset and the OSD/HPS.
// The master side is the sequencer. The slave side is the PLL/status environment.
interface pll_lock_sequencer_if;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_reset_n;
    logic       ready;
    logic       fault;
    logic       lol_seen;
    logic [1:0] retry_count;
    logic [2:0] state;

    modport master (
        input  pll_locked, relock_req,
        output pll_rst, sys_reset_n, ready, fault, lol_seen, retry_count, state
    );

    modport slave (
        output pll_locked, relock_req,
        input  pll_rst, sys_reset_n, ready, fault, lol_seen, retry_count, state
    );
endinterface

// File: rtl/pll_lock_sequencer.sv
// Sequences the PLL: reset pulse, lock wait with timeout, lock qualification, core release.
// It also handles loss-of-lock re-sequencing and a sticky fault after repeated timeouts.
module pll_lock_sequencer #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_STABLE  = 1024,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int MAX_RETRY    = 3,
    parameter int CNT_W        = 17
) (
    input  logic                  refclk,
    input  logic                  rst_n,
    pll_lock_sequencer_if.master  bus
);
    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABILIZE = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    typedef struct packed {
        logic pll_rst;
        logic sys_reset_n;
        logic ready;
        logic fault;
    } outs_t;

    localparam logic [CNT_W-1:0] ONE          = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRY);

    // Output values are decoded from the state being entered, so they change on the same edge as the state.
    function automatic outs_t decode(state_t s);
        outs_t o;
        o.pll_rst     = (s == S_RESET_PLL) || (s == S_FAULT);
        o.sys_reset_n = (s == S_RUN);
        o.ready       = (s == S_RUN);
        o.fault       = (s == S_FAULT);
        return o;
    endfunction

    state_t           state_q;
    outs_t            outs_q;
    logic [CNT_W-1:0] rcnt;
    logic [CNT_W-1:0] tcnt;
    logic [CNT_W-1:0] scnt;
    logic [1:0]       retry_q;
    logic             lol_q;
    logic             sync1;
    logic             lock_s;
    logic             timeout_hit;

    // NOTE: pll_locked is asynchronous to refclk. Two flops give it time to settle before any decision uses it.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            sync1  <= bus.pll_locked;
            lock_s <= sync1;
        end
    end

    // In WAIT_LOCK an arriving lock wins over the timeout. In STABILIZE the timeout wins over everything.
    assign timeout_hit = (tcnt == TIMEOUT_LAST) &&
                         (((state_q == S_WAIT_LOCK) && !lock_s) || (state_q == S_STABILIZE));

    // NOTE: all state uses non-blocking assignments, so every branch reads the pre-edge values of the counters.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state_q <= S_RESET_PLL;
            outs_q  <= decode(S_RESET_PLL);
            rcnt    <= '0;
            tcnt    <= '0;
            scnt    <= '0;
            retry_q <= '0;
            lol_q   <= 1'b0;
        end else if (timeout_hit) begin
            if (retry_q == RETRY_MAX) begin
                state_q <= S_FAULT;
                outs_q  <= decode(S_FAULT);
            end else begin
                retry_q <= (retry_q == 2'd3) ? 2'd3 : retry_q + 2'd1;
                rcnt    <= '0;
                state_q <= S_RESET_PLL;
                outs_q  <= decode(S_RESET_PLL);
            end
        end else begin
            unique case (state_q)
                S_RESET_PLL: begin
                    rcnt <= rcnt + ONE;
                    if (rcnt == RST_LAST) begin
                        tcnt    <= '0;
                        state_q <= S_WAIT_LOCK;
                        outs_q  <= decode(S_WAIT_LOCK);
                    end
                end
                S_WAIT_LOCK: begin
                    tcnt <= tcnt + ONE;
                    if (lock_s) begin
                        scnt    <= '0;
                        state_q <= S_STABILIZE;
                        outs_q  <= decode(S_STABILIZE);
                    end
                end
                S_STABILIZE: begin
                    // tcnt is never cleared here, so a chattering lock still hits the timeout.
                    tcnt <= tcnt + ONE;
                    if (!lock_s) begin
                        scnt    <= '0;
                        state_q <= S_WAIT_LOCK;
                        outs_q  <= decode(S_WAIT_LOCK);
                    end else begin
                        scnt <= scnt + ONE;
                        if (scnt == STABLE_LAST) begin
                            retry_q <= '0;
                            state_q <= S_RUN;
                            outs_q  <= decode(S_RUN);
                        end
                    end
                end
                S_RUN: begin
                    if (!lock_s || bus.relock_req) begin
                        lol_q   <= lol_q | !lock_s;
                        rcnt    <= '0;
                        state_q <= S_RESET_PLL;
                        outs_q  <= decode(S_RESET_PLL);
                    end
                end
                S_FAULT: begin
                    if (bus.relock_req) begin
                        retry_q <= '0;
                        rcnt    <= '0;
                        state_q <= S_RESET_PLL;
                        outs_q  <= decode(S_RESET_PLL);
                    end
                end
                default: begin
                    rcnt    <= '0;
                    state_q <= S_RESET_PLL;
                    outs_q  <= decode(S_RESET_PLL);
                end
            endcase
        end
    end

    assign bus.pll_rst     = outs_q.pll_rst;
    assign bus.sys_reset_n = outs_q.sys_reset_n;
    assign bus.ready       = outs_q.ready;
    assign bus.fault       = outs_q.fault;
    assign bus.lol_seen    = lol_q;
    assign bus.retry_count = retry_q;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with small parameters.
// It covers clean lock, chatter, timeout and fault, loss of lock, mid-sequence reset and coincident events.
module tb_pll_lock_sequencer;
    logic refclk = 1'b0;
    logic rst_n  = 1'b0;
    int   total  = 0;
    int   bad    = 0;

    pll_lock_sequencer_if bus ();

    pll_lock_sequencer #(
        .RST_CYCLES(4), .LOCK_STABLE(8), .LOCK_TIMEOUT(32), .MAX_RETRY(2), .CNT_W(6)
    ) dut (
        .refclk (refclk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 refclk = ~refclk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic count_while_rst(input logic level, output int n);
        n = 0;
        while (bus.pll_rst === level && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic count_until_ready(output int n);
        n = 0;
        while (bus.ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.pll_locked = 1'b0;
        bus.relock_req = 1'b0;
        ticks(3);
        total++; if (bus.state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", bus.state); end
        total++; if (bus.pll_rst !== 1'b1) begin bad++; $display("FAIL reset_pll_rst: got %b want 1", bus.pll_rst); end
        total++; if (bus.sys_reset_n !== 1'b0 || bus.ready !== 1'b0) begin
            bad++; $display("FAIL reset_core: sys_reset_n=%b ready=%b want 0 0", bus.sys_reset_n, bus.ready); end
        total++; if (bus.fault !== 1'b0 || bus.lol_seen !== 1'b0 || bus.retry_count !== 2'd0) begin
            bad++; $display("FAIL reset_status: fault=%b lol=%b retry=%0d want 0 0 0", bus.fault, bus.lol_seen, bus.retry_count); end
    endtask

    task automatic test_clean_lock();
        int n;
        rst_n = 1'b1;
        count_while_rst(1'b1, n);
        total++; if (n != 4) begin bad++; $display("FAIL clean_rst_width: got %0d want 4", n); end
        total++; if (bus.state !== 3'd1) begin bad++; $display("FAIL clean_wait_state: got %0d want 1", bus.state); end
        ticks(10);
        bus.pll_locked = 1'b1;
        count_until_ready(n);
        total++; if (n != 11) begin bad++; $display("FAIL clean_ready_latency: got %0d want 11", n); end
        total++; if (bus.sys_reset_n !== 1'b1 || bus.state !== 3'd3 || bus.pll_rst !== 1'b0) begin
            bad++; $display("FAIL clean_run: sys_reset_n=%b state=%0d pll_rst=%b want 1 3 0", bus.sys_reset_n, bus.state, bus.pll_rst); end
        total++; if (bus.retry_count !== 2'd0) begin bad++; $display("FAIL clean_retry: got %0d want 0", bus.retry_count); end
    endtask

    task automatic test_chatter();
        int n;
        bus.pll_locked = 1'b0;
        bus.relock_req = 1'b1;
        tick();
        bus.relock_req = 1'b0;
        total++; if (bus.state !== 3'd0 || bus.lol_seen !== 1'b0) begin
            bad++; $display("FAIL chatter_relock: state=%0d lol=%b want 0 0", bus.state, bus.lol_seen); end
        count_while_rst(1'b1, n);
        bus.pll_locked = 1'b1;
        ticks(3);
        total++; if (bus.state !== 3'd2) begin bad++; $display("FAIL chatter_stab1: got %0d want 2", bus.state); end
        ticks(2);
        bus.pll_locked = 1'b0;
        tick();
        bus.pll_locked = 1'b1;
        ticks(2);
        total++; if (bus.state !== 3'd1) begin bad++; $display("FAIL chatter_back_wait: got %0d want 1", bus.state); end
        tick();
        total++; if (bus.state !== 3'd2) begin bad++; $display("FAIL chatter_stab2: got %0d want 2", bus.state); end
        ticks(7);
        total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL chatter_ready_early: got %b want 0", bus.ready); end
        tick();
        total++; if (bus.ready !== 1'b1 || bus.state !== 3'd3 || bus.retry_count !== 2'd0) begin
            bad++; $display("FAIL chatter_run: ready=%b state=%0d retry=%0d want 1 3 0", bus.ready, bus.state, bus.retry_count); end
    endtask

    task automatic test_loss_of_lock();
        int n;
        bus.pll_locked = 1'b0;
        ticks(2);
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL lol_still_ready: got %b want 1", bus.ready); end
        tick();
        total++; if (bus.ready !== 1'b0 || bus.sys_reset_n !== 1'b0 || bus.pll_rst !== 1'b1) begin
            bad++; $display("FAIL lol_drop: ready=%b sys_reset_n=%b pll_rst=%b want 0 0 1", bus.ready, bus.sys_reset_n, bus.pll_rst); end
        total++; if (bus.lol_seen !== 1'b1 || bus.state !== 3'd0) begin
            bad++; $display("FAIL lol_flag: lol=%b state=%0d want 1 0", bus.lol_seen, bus.state); end
        bus.pll_locked = 1'b1;
        count_until_ready(n);
        total++; if (bus.state !== 3'd3 || bus.lol_seen !== 1'b1) begin
            bad++; $display("FAIL lol_rerun: state=%0d lol=%b want 3 1", bus.state, bus.lol_seen); end
    endtask

    task automatic test_timeout_fault();
        int n;
        bus.pll_locked = 1'b0;
        bus.relock_req = 1'b1;
        tick();
        bus.relock_req = 1'b0;
        for (int p = 0; p < 3; p++) begin
            total++; if (bus.retry_count !== 2'(p)) begin bad++; $display("FAIL to_retry%0d: got %0d want %0d", p, bus.retry_count, p); end
            count_while_rst(1'b1, n);
            total++; if (n != 4) begin bad++; $display("FAIL to_pulse%0d: got %0d want 4", p, n); end
            count_while_rst(1'b0, n);
            total++; if (n != 32) begin bad++; $display("FAIL to_wait%0d: got %0d want 32", p, n); end
        end
        total++; if (bus.fault !== 1'b1 || bus.state !== 3'd4 || bus.retry_count !== 2'd2) begin
            bad++; $display("FAIL to_fault: fault=%b state=%0d retry=%0d want 1 4 2", bus.fault, bus.state, bus.retry_count); end
        ticks(5);
        total++; if (bus.state !== 3'd4 || bus.pll_rst !== 1'b1 || bus.ready !== 1'b0) begin
            bad++; $display("FAIL to_fault_hold: state=%0d pll_rst=%b ready=%b want 4 1 0", bus.state, bus.pll_rst, bus.ready); end
        bus.relock_req = 1'b1;
        tick();
        bus.relock_req = 1'b0;
        total++; if (bus.state !== 3'd0 || bus.retry_count !== 2'd0 || bus.fault !== 1'b0) begin
            bad++; $display("FAIL to_relock: state=%0d retry=%0d fault=%b want 0 0 0", bus.state, bus.retry_count, bus.fault); end
        count_while_rst(1'b1, n);
        total++; if (n != 4) begin bad++; $display("FAIL to_relock_pulse: got %0d want 4", n); end
        bus.pll_locked = 1'b1;
        count_until_ready(n);
        total++; if (bus.state !== 3'd3) begin bad++; $display("FAIL to_recover: got %0d want 3", bus.state); end
    endtask

    task automatic test_reset_mid();
        int n;
        bus.pll_locked = 1'b0;
        bus.relock_req = 1'b1;
        tick();
        bus.relock_req = 1'b0;
        count_while_rst(1'b1, n);
        bus.pll_locked = 1'b1;
        ticks(8);
        total++; if (bus.state !== 3'd2) begin bad++; $display("FAIL mid_in_stab: got %0d want 2", bus.state); end
        rst_n = 1'b0;
        tick();
        total++; if (bus.state !== 3'd0 || bus.pll_rst !== 1'b1 || bus.ready !== 1'b0) begin
            bad++; $display("FAIL mid_reset: state=%0d pll_rst=%b ready=%b want 0 1 0", bus.state, bus.pll_rst, bus.ready); end
        total++; if (bus.lol_seen !== 1'b0 || bus.retry_count !== 2'd0) begin
            bad++; $display("FAIL mid_reset_status: lol=%b retry=%0d want 0 0", bus.lol_seen, bus.retry_count); end
        rst_n = 1'b1;
        count_while_rst(1'b1, n);
        total++; if (n != 4) begin bad++; $display("FAIL mid_pulse: got %0d want 4", n); end
        count_until_ready(n);
        total++; if (n != 9) begin bad++; $display("FAIL mid_ready_latency: got %0d want 9", n); end
    endtask

    task automatic test_simultaneous();
        int n;
        bus.pll_locked = 1'b0;
        ticks(2);
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL sim_pre: ready=%b want 1", bus.ready); end
        bus.relock_req = 1'b1;
        tick();
        bus.relock_req = 1'b0;
        total++; if (bus.state !== 3'd0 || bus.lol_seen !== 1'b1 || bus.pll_rst !== 1'b1) begin
            bad++; $display("FAIL sim_both: state=%0d lol=%b pll_rst=%b want 0 1 1", bus.state, bus.lol_seen, bus.pll_rst); end
        count_while_rst(1'b1, n);
        total++; if (n != 4) begin bad++; $display("FAIL sim_pulse: got %0d want 4", n); end
        ticks(5);
        bus.relock_req = 1'b1;
        tick();
        bus.relock_req = 1'b0;
        total++; if (bus.state !== 3'd1 || bus.pll_rst !== 1'b0) begin
            bad++; $display("FAIL sim_wait_relock: state=%0d pll_rst=%b want 1 0", bus.state, bus.pll_rst); end
        count_while_rst(1'b0, n);
        total++; if (n != 26) begin bad++; $display("FAIL sim_wait_timeout: got %0d want 26", n); end
        total++; if (bus.retry_count !== 2'd1 || bus.state !== 3'd0) begin
            bad++; $display("FAIL sim_retry: retry=%0d state=%0d want 1 0", bus.retry_count, bus.state); end
    endtask

    initial begin
        bus.pll_locked = 1'b0;
        bus.relock_req = 1'b0;
        test_reset();
        test_clean_lock();
        test_chatter();
        test_loss_of_lock();
        test_timeout_fault();
        test_reset_mid();
        test_simultaneous();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Sequences the system PLL on the 50 MHz reference clock.
- Pulses the PLL reset, waits for lock with a timeout, and qualifies lock as stable.
- Only then releases the synchronous core reset to the emulation logic.
- Detects loss of lock and re-sequences. After repeated lock failures it raises a sticky fault for the OSD/HPS status word.

Parameters:
- RST_CYCLES, 16: width of the PLL reset pulse in refclk cycles (≥2).
- LOCK_STABLE, 1024: number of consecutive synchronized-lock cycles required before the core is released.
- LOCK_TIMEOUT, 65536: maximum cycles from PLL reset release to a qualified lock.
- MAX_RETRY, 3: number of re-sequence attempts after a timeout before FAULT.
- CNT_W, 17: counter width; must hold max(RST_CYCLES, LOCK_STABLE, LOCK_TIMEOUT).

Ports:
- refclk  in  1  reference clock; sole clock of this block.
- rst_n  in  1  synchronous, active-low block reset.
- pll_locked  in  1  PLL locked output; asynchronous to refclk.
- relock_req  in  1  one-cycle request to re-sequence the PLL (from an OSD/HPS clock change).
- pll_rst  out  1  active-high reset to the PLL.
- sys_reset_n  out  1  active-low core reset.
- ready  out  1  high while in RUN.
- fault  out  1  high while in FAULT.
- lol_seen  out  1  sticky: lock was lost while in RUN.
- retry_count  out  2  number of timeout retries in the current sequence, saturating at 3.
- state  out  3  encoded state for debug (RESET_PLL=0, WAIT_LOCK=1, STABILIZE=2, RUN=3, FAULT=4).

Behaviour:
- Synchronizer:
  - pll_locked passes through two refclk flops to form lock_s, so the FSM sees it 2 cycles late.
  - The synchronizer flops reset to 0.
- Outputs:
  - All outputs are registered and decode the current state register.
  - pll_rst=1 in RESET_PLL and FAULT.
  - sys_reset_n=ready=1 only in RUN.
  - fault=1 only in FAULT.
- Reset: rst_n=0 at a clock edge gives:
  - state=RESET_PLL; rcnt, tcnt and scnt all 0; retry_count=0; lol_seen=0.
  - pll_rst=1, sys_reset_n=0, ready=0, fault=0.
  - Reset mid-sequence aborts any state immediately on that edge.
- RESET_PLL:
  - rcnt increments each cycle.
  - At rcnt==RST_CYCLES-1, go to WAIT_LOCK and clear tcnt. pll_rst is therefore high for exactly RST_CYCLES cycles.
- WAIT_LOCK:
  - tcnt increments each cycle.
  - If lock_s=1, go to STABILIZE with scnt=0.
  - Otherwise, at tcnt==LOCK_TIMEOUT-1, run the timeout rule.
- STABILIZE:
  - tcnt keeps counting; it is not cleared by lock drops, which bounds a chattering lock.
  - lock_s=1: scnt increments. At scnt==LOCK_STABLE-1, go to RUN. STABILIZE therefore lasts exactly LOCK_STABLE cycles on a clean lock.
  - lock_s=0: go back to WAIT_LOCK with scnt=0.
  - If tcnt==LOCK_TIMEOUT-1, run the timeout rule. Timeout takes priority over RUN entry on the same cycle.
- Timeout rule:
  - If retry_count==MAX_RETRY, go to FAULT.
  - Otherwise retry_count++ and go to RESET_PLL with rcnt=0.
- RUN:
  - On entry, retry_count clears to 0.
  - lock_s=0: set lol_seen=1 and go to RESET_PLL.
  - relock_req=1: go to RESET_PLL; lol_seen is unchanged.
  - On both in the same cycle, go to RESET_PLL and set lol_seen.
- FAULT:
  - Holds pll_rst=1.
  - Exits only on rst_n=0, or on relock_req=1, which clears retry_count and goes to RESET_PLL.
- relock_req outside RUN and FAULT is ignored; the sequence is already in progress.
- lol_seen clears only on rst_n=0.
- Nominal lock latency: pll_locked rising at cycle T gives lock_s at T+2, STABILIZE at T+3 and ready at T+3+LOCK_STABLE.

Test Plan (RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, MAX_RETRY=2, CNT_W=6):
- Clean lock:
  - Stimulus: release rst_n; raise pll_locked 10 cycles after pll_rst falls.
  - Response: pll_rst high exactly 4 cycles; ready and sys_reset_n rise exactly 11 cycles after pll_locked rises; retry_count=0; state=3.
- Chatter:
  - Stimulus: pll_locked high for 5 cycles, low for 1, then steady.
  - Response: state returns 2→1→2; ready rises 11 cycles after the final rise; no retry occurs while tcnt<32.
- Timeout retry and fault:
  - Stimulus: pll_locked held low.
  - Response: three 4-cycle pll_rst pulses, with retry_count 0→1→2; fault=1 and state=4 after the third 32-cycle wait; pll_rst stays high.
  - Then pulse relock_req: retry_count=0, state=0, and pll_rst pulses 4 cycles again.
- Loss of lock:
  - Stimulus: in RUN, drop pll_locked.
  - Response: 3 cycles later ready=0, sys_reset_n=0, pll_rst=1 and lol_seen=1. Restoring lock gives RUN again with lol_seen still 1.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 while in STABILIZE with scnt=5.
  - Response: next edge gives state=0, pll_rst=1, ready=0, lol_seen=0, retry_count=0.
  - After release, the full 4+wait+8 sequence repeats.
- Simultaneous events:
  - Stimulus: in RUN, relock_req=1 in the same cycle lock_s falls.
  - Response: single transition to RESET_PLL with lol_seen=1.
  - Stimulus: relock_req during WAIT_LOCK.
  - Response: ignored, with no change to tcnt or state.
